// File: rtl/rom_sweep_pkg.sv
// rtl/rom_sweep_pkg.sv - shared state type, checksum width and credit helper for the ROM sweep reader
package rom_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } sweep_state_e;

  localparam int CSUM_W = 16;

  // A read may only be issued if the FIFO can absorb it together with any read still in flight.
  function automatic logic has_credit(input int unsigned fifo_count,
                                      input int unsigned in_flight,
                                      input int unsigned depth);
    return (fifo_count + in_flight) < depth;
  endfunction

endpackage

// File: rtl/rom_sweep_fifo.sv
// rtl/rom_sweep_fifo.sv - synchronous FIFO holding {addr, data} words for the output stream
module rom_sweep_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rom_sweep_reader.sv
// rtl/rom_sweep_reader.sv - sweeps a ROM address range and streams {addr, data} with a running checksum
module rom_sweep_reader
  import rom_sweep_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int READ_LAT   = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              done,
  output logic [CSUM_W-1:0] checksum
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  sweep_state_e              state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [ADDR_W-1:0]         last_q, last_d;
  logic [CSUM_W-1:0]         csum_q, csum_d;
  logic                      issue, push, in_flight, xfer;
  logic [ADDR_W+DATA_W-1:0]  push_word, head_word;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_full_unused, fifo_empty;

  if (READ_LAT == 0) begin : g_lat0
    assign push      = issue;
    assign push_word = {addr_q, data};
    assign in_flight = 1'b0;
  end else begin : g_lat1
    // One-stage tag pipeline: the address issued last cycle pairs with this cycle's ROM data.
    logic              pipe_vld_q;
    logic [ADDR_W-1:0] pipe_addr_q, pipe_addr_d;

    assign pipe_addr_d = issue ? addr_q : pipe_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_vld_q  <= 1'b0;
        pipe_addr_q <= '0;
      end else begin
        pipe_vld_q  <= issue;
        pipe_addr_q <= pipe_addr_d;
      end
    end

    assign push      = pipe_vld_q;
    assign push_word = {pipe_addr_q, data};
    assign in_flight = pipe_vld_q;
  end

  rom_sweep_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_word),
    .pop   (xfer),
    .rdata (head_word),
    .count (fifo_count),
    .full  (fifo_full_unused),
    .empty (fifo_empty)
  );

  assign m_valid          = ~fifo_empty;
  assign {m_addr, m_data} = head_word;
  assign xfer             = m_valid & m_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    csum_d  = csum_q;
    issue   = 1'b0;
    if (xfer) csum_d = csum_q + CSUM_W'(m_data);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = first_addr;
          last_d  = last_addr;
          csum_d  = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (has_credit(32'(fifo_count), 32'(in_flight), FIFO_DEPTH)) begin
          issue = 1'b1;
          // Equality, not magnitude, so wrapped ranges terminate correctly.
          if (addr_q == last_q) state_d = ST_DRAIN;
          else                  addr_d  = addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!in_flight && (fifo_empty || (fifo_count == CNT_W'(1) && xfer))) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      csum_q  <= csum_d;
    end
  end

  assign address  = addr_q;
  assign busy     = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign checksum = csum_q;

endmodule

// File: tb/tb_rom_sweep_reader.sv
// tb/tb_rom_sweep_reader.sv - runs READ_LAT=0 and READ_LAT=1 readers side by side against a sweep model
module tb_rom_sweep_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        m_ready = 1'b0;
  logic [7:0]  first_addr = '0;
  logic [7:0]  last_addr = '0;
  logic [7:0]  address [2];
  logic [7:0]  data0, data1;
  logic        m_valid [2];
  logic [7:0]  m_addr [2];
  logic [7:0]  m_data [2];
  logic        busy [2];
  logic        done [2];
  logic [15:0] checksum [2];

  rom_sweep_reader #(.ADDR_W(8), .DATA_W(8), .READ_LAT(0), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .address(address[0]), .data(data0), .m_valid(m_valid[0]), .m_ready(m_ready),
    .m_addr(m_addr[0]), .m_data(m_data[0]), .busy(busy[0]), .done(done[0]), .checksum(checksum[0]));

  rom_sweep_reader #(.ADDR_W(8), .DATA_W(8), .READ_LAT(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .address(address[1]), .data(data1), .m_valid(m_valid[1]), .m_ready(m_ready),
    .m_addr(m_addr[1]), .m_data(m_data[1]), .busy(busy[1]), .done(done[1]), .checksum(checksum[1]));

  // ROM contents: data = addr ^ 8'hA5, combinational and registered flavours.
  assign data0 = address[0] ^ 8'hA5;
  always @(posedge clk) data1 <= address[1] ^ 8'hA5;

  int          ncyc = 0;
  logic [15:0] got [2][$];
  int          done_cnt [2] = '{0, 0};
  int          stall_viol [2] = '{0, 0};
  int          ovf [2] = '{0, 0};
  int          issue_cyc [2] = '{0, 0};
  int          fv_cyc [2] = '{0, 0};
  int          acc_cyc [2] = '{0, 0};
  int          done_cyc [2] = '{0, 0};
  logic        busy_prev [2] = '{1'b0, 1'b0};
  logic        fv_pend [2] = '{1'b0, 1'b0};
  logic        stall_prev [2] = '{1'b0, 1'b0};
  logic [15:0] held [2] = '{16'h0, 16'h0};

  always @(negedge clk) begin
    ncyc++;
    for (int g = 0; g < 2; g++) begin
      if (busy[g] && !busy_prev[g]) begin
        issue_cyc[g] = ncyc;
        fv_pend[g]   = 1'b1;
      end
      if (m_valid[g] && fv_pend[g]) begin
        fv_cyc[g]  = ncyc;
        fv_pend[g] = 1'b0;
      end
      if (stall_prev[g] && (!m_valid[g] || {m_addr[g], m_data[g]} !== held[g])) stall_viol[g]++;
      stall_prev[g] = m_valid[g] && !m_ready && rst_n;
      held[g]       = {m_addr[g], m_data[g]};
      if (m_valid[g] && m_ready) begin
        got[g].push_back({m_addr[g], m_data[g]});
        acc_cyc[g] = ncyc;
      end
      if (done[g]) begin
        done_cnt[g]++;
        done_cyc[g] = ncyc;
      end
      busy_prev[g] = busy[g];
    end
    if (u_dut0.u_fifo.count_q > 3'd4) ovf[0]++;
    if (u_dut1.u_fifo.count_q > 3'd4) ovf[1]++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int dbase0, input int dbase1, input int mode, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done_cnt[0] > dbase0 && done_cnt[1] > dbase1) begin
        ok = 1'b1;
        break;
      end
      m_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
      tick();
    end
    m_ready = 1'b1;
    tick();
    tick();
  endtask

  // Expected stream from the sweep rules: (l - f) mod 256 + 1 words starting at f, wrapping at 256.
  task automatic run_sweep(input string tag, input logic [7:0] f, input logic [7:0] l, input int mode);
    int          base [2], dbase [2], sbase [2];
    int          n, mism, a, cnt;
    int unsigned sum;
    logic [15:0] exp_w [$];
    logic        ok;
    n   = ((int'(l) - int'(f) + 256) % 256) + 1;
    sum = 0;
    for (int k = 0; k < n; k++) begin
      a = (int'(f) + k) % 256;
      exp_w.push_back({8'(a), 8'(a ^ 'hA5)});
      sum = (sum + (a ^ 'hA5)) % 65536;
    end
    for (int g = 0; g < 2; g++) begin
      base[g]  = got[g].size();
      dbase[g] = done_cnt[g];
      sbase[g] = stall_viol[g];
    end
    first_addr = f;
    last_addr  = l;
    m_ready    = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
    start      = 1'b1;
    tick();
    start = 1'b0;
    wait_done(dbase[0], dbase[1], mode, ok);
    check($sformatf("%s_timeout", tag), 32'(ok), 32'd1);
    for (int g = 0; g < 2; g++) begin
      cnt  = got[g].size() - base[g];
      mism = 0;
      for (int k = 0; k < n && k < cnt; k++)
        if (got[g][base[g] + k] !== exp_w[k]) mism++;
      check($sformatf("%s_lat%0d_words", tag, g), 32'(cnt), 32'(n));
      check($sformatf("%s_lat%0d_seq", tag, g), 32'(mism), 32'd0);
      check($sformatf("%s_lat%0d_checksum", tag, g), 32'(checksum[g]), sum);
      check($sformatf("%s_lat%0d_done_pulses", tag, g), 32'(done_cnt[g] - dbase[g]), 32'd1);
      check($sformatf("%s_lat%0d_busy_end", tag, g), 32'(busy[g]), 32'd0);
      check($sformatf("%s_lat%0d_stall", tag, g), 32'(stall_viol[g] - sbase[g]), 32'd0);
      check($sformatf("%s_lat%0d_overflow", tag, g), 32'(ovf[g]), 32'd0);
      if (mode == 0) begin
        check($sformatf("%s_lat%0d_first_valid", tag, g), 32'(fv_cyc[g] - issue_cyc[g]), 32'(1 + g));
        check($sformatf("%s_lat%0d_done_time", tag, g), 32'(done_cyc[g] - issue_cyc[g]), 32'(n + 1 + g));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_lat%0d_m_valid", tag, g), 32'(m_valid[g]), 32'd0);
      check($sformatf("%s_lat%0d_busy", tag, g), 32'(busy[g]), 32'd0);
      check($sformatf("%s_lat%0d_done", tag, g), 32'(done[g]), 32'd0);
      check($sformatf("%s_lat%0d_checksum", tag, g), 32'(checksum[g]), 32'd0);
      check($sformatf("%s_lat%0d_address", tag, g), 32'(address[g]), 32'd0);
    end
  endtask

  initial begin
    int          base [2], dbase [2], sbase [2];
    logic        ok;
    logic [7:0]  rf, rl;

    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    run_sweep("full", 8'd0, 8'd255, 0);
    run_sweep("wrap", 8'd250, 8'd3, 0);
    run_sweep("rand_ready", 8'd0, 8'd255, 1);
    for (int r = 0; r < 2; r++) begin
      rf = 8'($urandom_range(0, 255));
      rl = 8'($urandom_range(0, 255));
      run_sweep($sformatf("rand_range%0d", r), rf, rl, 1);
    end

    // Single-word sweep with the consumer stalled for the first cycles.
    for (int g = 0; g < 2; g++) begin
      base[g]  = got[g].size();
      dbase[g] = done_cnt[g];
      sbase[g] = stall_viol[g];
    end
    m_ready    = 1'b0;
    first_addr = 8'h42;
    last_addr  = 8'h42;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    wait_done(dbase[0], dbase[1], 0, ok);
    check("single_timeout", 32'(ok), 32'd1);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("single_lat%0d_words", g), 32'(got[g].size() - base[g]), 32'd1);
      check($sformatf("single_lat%0d_word", g), 32'(got[g][got[g].size() - 1]), 32'h42E7);
      check($sformatf("single_lat%0d_held", g), 32'(acc_cyc[g] - fv_cyc[g]), 32'(5 - g));
      check($sformatf("single_lat%0d_done_after_accept", g), 32'(done_cyc[g] - acc_cyc[g]), 32'd1);
      check($sformatf("single_lat%0d_checksum", g), 32'(checksum[g]), 32'h00E7);
      check($sformatf("single_lat%0d_stall", g), 32'(stall_viol[g] - sbase[g]), 32'd0);
      check($sformatf("single_lat%0d_done_pulses", g), 32'(done_cnt[g] - dbase[g]), 32'd1);
    end

    // Reset in the middle of a full sweep, then a clean restart.
    base[0]    = got[0].size();
    first_addr = 8'd0;
    last_addr  = 8'd255;
    m_ready    = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (got[0].size() - base[0] >= 100) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("midrst_reached_word100", 32'(ok), 32'd1);
    dbase[0] = done_cnt[0];
    dbase[1] = done_cnt[1];
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst_async");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_lat0_no_done", 32'(done_cnt[0] - dbase[0]), 32'd0);
    check("midrst_lat1_no_done", 32'(done_cnt[1] - dbase[1]), 32'd0);
    run_sweep("post_reset", 8'd0, 8'd255, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_sweep_reader.md
Name: rom_sweep_reader

Overview:
- Address sequencer and data capture stage that sits directly in front of the rom block: drives its address input and consumes its data output.
- On a start pulse it sweeps a programmed address range, captures each word after the ROM read latency, and forwards {addr, data} on a valid/ready stream.
- Keeps a running 16-bit checksum of the words it delivers.
- Used for post-route ROM dumps and content checks in place of an open-loop bench loop.

Parameters:
- ADDR_W, 8, ROM address width.
- DATA_W, 8, ROM data width.
- READ_LAT, 0, ROM read latency in clk cycles; legal values 0 (combinational) or 1 (registered).
- FIFO_DEPTH, 4, output buffer entries; power of two, must be >= READ_LAT+2.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only while idle.
- first_addr  in  ADDR_W  first address of the sweep; sampled on start.
- last_addr  in  ADDR_W  last address of the sweep, inclusive; sampled on start.
- address  out  ADDR_W  to the rom address input.
- data  in  DATA_W  from the rom data output.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word.
- m_addr  out  ADDR_W  address of the current output word.
- m_data  out  DATA_W  data of the current output word.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the final word is accepted.
- checksum  out  16  mod-2^16 sum of all accepted m_data, zero-extended.

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM = IDLE; FIFO empty; in-flight counter 0; checksum 0.
- FSM states IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On start=1, latch first_addr/last_addr, set address=first_addr, clear checksum, go to ISSUE.
  - busy=1 from the cycle after start.
  - start in any other state is ignored.
- ISSUE:
  - Issue one read per cycle when credit is available: fifo_count + in_flight < FIFO_DEPTH.
  - Issuing a read means address is held for the read cycle; for READ_LAT=0, data is captured into the FIFO in the same cycle.
  - For READ_LAT=1, the address is tagged in a one-stage pipeline and data is captured next cycle.
  - address advances by 1 only on issue; it holds otherwise.
  - After issuing last_addr, go to DRAIN.
- Wrap-around:
  - If last_addr < first_addr, the sweep wraps modulo 2^ADDR_W through the maximum address back to last_addr.
  - first_addr == last_addr is a single-word sweep.
  - A full sweep (first=0, last=2^ADDR_W-1) is 2^ADDR_W words.
  - The last-address test uses equality, never magnitude compare.
- DRAIN: wait until in_flight == 0 and the FIFO is empty with the last word accepted, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE. address holds its last value.
- Output stream:
  - m_valid = FIFO not empty; m_addr and m_data come from the FIFO head.
  - Transfer happens on m_valid & m_ready.
  - m_addr, m_data and m_valid must stay stable while m_valid=1 and m_ready=0.
  - No word is dropped or duplicated under any m_ready pattern.
- FIFO push and pop in the same cycle is legal when full: pop then push, count unchanged.
- checksum updates on each transfer: checksum <= checksum + m_data. Reads mid-sweep show the partial sum.
- Throughput: with m_ready held 1, one word per cycle after READ_LAT+1 cycles of startup.
- Reset mid-sweep: everything returns to reset values immediately; no done pulse; a fresh start is required.

Decomposition:
- Package rom_sweep_pkg: FSM state enum, checksum width constant (16), and the credit-check helper function.
- One sub-module: rom_sweep_fifo, a synchronous FIFO of depth FIFO_DEPTH with width ADDR_W+DATA_W, providing count, full and empty. The top level holds the FSM, address counter, latency pipeline and checksum.

Test Plan:
- ROM content data=addr^8'hA5, READ_LAT=0, first=0, last=255, m_ready=1:
  - Expect 256 words, m_addr 0..255 consecutively, m_data = addr^A5.
  - Expect done exactly 256+1 cycles after the first issue, checksum = 16'h7F80.
- READ_LAT=1, same sweep: identical word sequence and checksum; first m_valid appears one cycle later than with READ_LAT=0.
- first=250, last=3 (wrap), m_ready=1: expect 10 words with addresses 250..255,0..3 in order, then a single done pulse.
- Random m_ready at 30% duty over the full sweep:
  - Words stay stable while stalled; no drop or duplicate; 256 transfers.
  - FIFO never overflows (assert fifo_count <= FIFO_DEPTH).
  - checksum matches the first scenario.
- first=last=16'h42 (single word), m_ready=0 for 5 cycles then 1: m_valid is held 5 cycles, one transfer of addr 0x42, done one cycle after acceptance.
- rst_n asserted at word 100 of a full sweep:
  - Outputs clear asynchronously, with m_valid=0, busy=0 and checksum=0.
  - A start pulse after release runs a clean full sweep to done.
